// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared phase constants, atan table and phase-detector state encoding
package dds_pkg;

  localparam int PHASE_FULL = 36000;
  localparam int PHASE_HALF = 18000;
  localparam int ATAN_LEN   = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_FIN  = 2'd2
  } det_state_t;

  function automatic logic [12:0] atan_cdeg(input logic [3:0] k);
    case (k)
      4'd0:    atan_cdeg = 13'd4500;
      4'd1:    atan_cdeg = 13'd2657;
      4'd2:    atan_cdeg = 13'd1404;
      4'd3:    atan_cdeg = 13'd713;
      4'd4:    atan_cdeg = 13'd358;
      4'd5:    atan_cdeg = 13'd179;
      4'd6:    atan_cdeg = 13'd90;
      4'd7:    atan_cdeg = 13'd45;
      4'd8:    atan_cdeg = 13'd22;
      4'd9:    atan_cdeg = 13'd11;
      4'd10:   atan_cdeg = 13'd6;
      4'd11:   atan_cdeg = 13'd3;
      default: atan_cdeg = 13'd0;
    endcase
  endfunction

endpackage

// File: rtl/iq_phase_detector_cordic.sv
// rtl/iq_phase_detector_cordic.sv - iterative vectoring CORDIC datapath (x/y/z, iteration counter, atan lookup)
module cordic_vectoring
  import dds_pkg::*;
#(
  parameter int ITER = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic signed [7:0]  i_in,
  input  logic signed [7:0]  q_in,
  output logic        [9:0]  mag,
  output logic signed [16:0] z,
  output logic               last
);

  logic signed [10:0] x, y, xs, ys, i_ext, q_ext;
  logic signed [16:0] step;
  logic        [3:0]  iter_cnt;

  // Small negatives shift toward zero; a floored -1 would keep pumping x in the late iterations.
  function automatic logic signed [10:0] shr(input logic signed [10:0] v, input logic [3:0] k);
    shr = v[10] ? -((-v) >>> k) : (v >>> k);
  endfunction

  // x/y carry one fractional bit: samples enter doubled, mag is rounded back down.
  always_comb begin
    i_ext = {{2{i_in[7]}}, i_in, 1'b0};
    q_ext = {{2{q_in[7]}}, q_in, 1'b0};
    xs    = shr(x, iter_cnt);
    ys    = shr(y, iter_cnt);
    step  = $signed({4'b0000, atan_cdeg(iter_cnt)});
  end

  assign last = (iter_cnt == 4'(ITER - 1));
  assign mag  = 10'((x + 11'sd1) >>> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      iter_cnt <= '0;
    end else if (load) begin
      iter_cnt <= '0;
      if (i_in[7]) begin
        x <= -i_ext;
        y <= -q_ext;
        z <= 17'(PHASE_HALF);
      end else begin
        x <= i_ext;
        y <= q_ext;
        z <= '0;
      end
    end else if (run) begin
      iter_cnt <= iter_cnt + 4'd1;
      if (!y[10]) begin
        x <= x + ys;
        y <= y - xs;
        z <= z + step;
      end else begin
        x <= x - ys;
        y <= y + xs;
        z <= z - step;
      end
    end
  end

endmodule

// File: rtl/iq_phase_detector.sv
// rtl/iq_phase_detector.sv - I/Q sample to phase, magnitude and wrapped phase-step estimate
module iq_phase_detector
  import dds_pkg::*;
#(
  parameter int ITER = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  i_in,
  input  logic signed [7:0]  q_in,
  output logic               out_valid,
  output logic        [15:0] phase,
  output logic        [9:0]  mag,
  output logic signed [15:0] freq
);

  localparam logic signed [17:0] FULL18 = 18'(PHASE_FULL);
  localparam logic signed [17:0] HALF18 = 18'(PHASE_HALF);

  det_state_t         state, state_nx;
  logic               load, last, zero_smp, hist_valid;
  logic        [9:0]  c_mag;
  logic signed [16:0] c_z;
  logic        [15:0] prev, phase_nx;
  logic signed [17:0] diff, diff_w;

  assign in_ready = (state == ST_IDLE);
  assign load     = in_valid && in_ready;

  cordic_vectoring #(.ITER(ITER)) u_cordic (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .run  (state == ST_ROT),
    .i_in (i_in),
    .q_in (q_in),
    .mag  (c_mag),
    .z    (c_z),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = ST_ROT;
      ST_ROT:  if (last)     state_nx = ST_FIN;
      ST_FIN:                state_nx = ST_IDLE;
      default:               state_nx = ST_IDLE;
    endcase
  end

  // A zero vector leaves z summing the whole table, so its phase is forced to 0.
  always_comb begin
    if (zero_smp)    phase_nx = '0;
    else if (c_z[16]) phase_nx = 16'(c_z + 17'(PHASE_FULL));
    else             phase_nx = c_z[15:0];
    diff = $signed({2'b00, phase_nx}) - $signed({2'b00, prev});
    if (diff >= HALF18)      diff_w = diff - FULL18;
    else if (diff < -HALF18) diff_w = diff + FULL18;
    else                     diff_w = diff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      phase      <= '0;
      mag        <= '0;
      freq       <= '0;
      prev       <= '0;
      hist_valid <= 1'b0;
      zero_smp   <= 1'b0;
    end else begin
      out_valid <= (state == ST_FIN);
      if (load) zero_smp <= (i_in == '0) && (q_in == '0);
      if (clr)  hist_valid <= 1'b0;
      if (state == ST_FIN) begin
        phase <= phase_nx;
        mag   <= c_mag;
        freq  <= (hist_valid && !clr) ? 16'(diff_w) : '0;
        if (!clr) begin
          prev       <= phase_nx;
          hist_valid <= 1'b1;
        end
      end
    end
  end

endmodule
